// File: rtl/dice_roller_multi.sv
// dice_roller_multi: debounced push-button roller driving up to four dice from a 16-bit Galois LFSR.
// Optional per-die hold port and behaviour enabled by defining DICE_HOLD_EN.
module dice_roller_multi #(
   parameter int unsigned NUM_DICE        = 2,
   parameter int unsigned FACES           = 6,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned ROLL_CYCLES     = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn,
`ifdef DICE_HOLD_EN
   input  logic [NUM_DICE-1:0]   hold,
`endif
   output logic [4*NUM_DICE-1:0] dice_out,
   output logic [5:0]            dice_sum,
   output logic                  rolling,
   output logic                  result_valid
);
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RC_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROLL_CYCLES - 1);
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic {IDLE, ROLL} state_t;
   state_t state, state_nxt;

   logic                  btn_meta, btn_s, btn_db, btn_db_q, press;
   logic [DB_W-1:0]       db_cnt;
   logic [15:0]           lfsr;
   logic [RC_W-1:0]       roll_cnt, roll_cnt_nxt;
   logic [4*NUM_DICE-1:0] faces, dice_nxt;
   logic [NUM_DICE-1:0]   keep;
   logic [5:0]            sum_nxt;
   logic                  rolling_nxt, valid_nxt;

   // Level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
         press    <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_meta <= btn;
         btn_s    <= btn_meta;
         btn_db_q <= btn_db;
         press    <= btn_db & ~btn_db_q;
         if (btn_s == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
   end

   always_comb begin
      faces = '0;
      keep  = '0;
      for (int unsigned i = 0; i < NUM_DICE; i++) begin
         faces[4*i +: 4] = 4'((32'(lfsr[4*i +: 4]) % FACES) + 1);
`ifdef DICE_HOLD_EN
         // A die that has never rolled has no value worth holding.
         keep[i] = hold[i] && (dice_out[4*i +: 4] != 4'd0);
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      roll_cnt_nxt = roll_cnt;
      dice_nxt     = dice_out;
      sum_nxt      = dice_sum;
      rolling_nxt  = rolling;
      valid_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt    = ROLL;
               roll_cnt_nxt = '0;
               rolling_nxt  = 1'b1;
            end
         end
         ROLL: begin
            for (int unsigned i = 0; i < NUM_DICE; i++)
               if (!keep[i]) dice_nxt[4*i +: 4] = faces[4*i +: 4];
            roll_cnt_nxt = roll_cnt + 1'b1;
            if (roll_cnt == RC_LAST) begin
               state_nxt    = IDLE;
               roll_cnt_nxt = '0;
               rolling_nxt  = 1'b0;
               valid_nxt    = 1'b1;
               sum_nxt      = '0;
               for (int unsigned i = 0; i < NUM_DICE; i++)
                  sum_nxt = sum_nxt + 6'(dice_nxt[4*i +: 4]);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         roll_cnt     <= '0;
         dice_out     <= '0;
         dice_sum     <= '0;
         rolling      <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         roll_cnt     <= roll_cnt_nxt;
         dice_out     <= dice_nxt;
         dice_sum     <= sum_nxt;
         rolling      <= rolling_nxt;
         result_valid <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_dice_roller_multi.sv
// Scoreboard bench for dice_roller_multi: driver pushes expected results, negedge monitor pops on result_valid.
// Hold scenario compiled in only when DICE_HOLD_EN is defined.
module tb_dice_roller_multi;
   localparam int ROLL = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct packed {
      logic [3:0] d0;
      logic [3:0] d1;
      logic [5:0] sum;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic [7:0] dice_out;
   logic [5:0] dice_sum;
   logic       rolling;
   logic       result_valid;
`ifdef DICE_HOLD_EN
   logic [1:0] hold;
`endif

   exp_t        exp_q[$];
   exp_t        last_exp = '0;
   logic [1:0]  hold_mask = 2'b00;
   logic [15:0] model_lfsr;
   int          checks = 0;
   int          errors = 0;

   dice_roller_multi #(
      .NUM_DICE(2),
      .FACES(6),
      .DEBOUNCE_CYCLES(4),
      .ROLL_CYCLES(ROLL),
      .LFSR_SEED(SEED)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn(btn),
`ifdef DICE_HOLD_EN
      .hold(hold),
`endif
      .dice_out(dice_out),
      .dice_sum(dice_sum),
      .rolling(rolling),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
      logic [15:0] v;
      v = s;
      for (int i = 0; i < n; i++)
         v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   function automatic logic [3:0] face(input logic [3:0] nib);
      return (nib % 4'd6) + 4'd1;
   endfunction

   // Reference LFSR: value held here between edges is what the DUT samples at the next edge.
   always @(posedge clk) begin
      if (reset) model_lfsr <= SEED;
      else       model_lfsr <= lfsr_adv(model_lfsr, 1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_roll(input logic [15:0] lf);
      exp_t e;
      e.d0  = (hold_mask[0] && last_exp.d0 != 4'd0) ? last_exp.d0 : face(lf[3:0]);
      e.d1  = (hold_mask[1] && last_exp.d1 != 4'd0) ? last_exp.d1 : face(lf[7:4]);
      e.sum = 6'(e.d0) + 6'(e.d1);
      exp_q.push_back(e);
      last_exp = e;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=1 required=0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("die0", dice_out[3:0], e.d0);
            check("die1", dice_out[7:4], e.d1);
            check("sum", dice_sum, e.sum);
            check("die0_range", (dice_out[3:0] >= 4'd1 && dice_out[3:0] <= 4'd6), 1);
            check("die1_range", (dice_out[7:4] >= 4'd1 && dice_out[7:4] <= 4'd6), 1);
         end
      end
   end

   // btn waveform: hi1 high, lo low, hi2 high, sampled from edge E (k=0).
   // r1/r2: cycle index at which rolling is expected to rise (-1 = none).
   task automatic run_seq(input int hi1, input int lo, input int hi2,
                          input int r1, input int r2, input int ncyc);
      logic [15:0] lf;
      logic        exp_r, exp_v;
      lf = model_lfsr;
      if (r1 >= 0) push_roll(lfsr_adv(lf, r1 + ROLL));
      if (r2 >= 0) push_roll(lfsr_adv(lf, r2 + ROLL));
      for (int k = 0; k < ncyc; k++) begin
         btn = (k < hi1) || (k >= hi1 + lo && k < hi1 + lo + hi2);
         @(posedge clk);
         #1;
         exp_r = (r1 >= 0 && k >= r1 && k < r1 + ROLL) || (r2 >= 0 && k >= r2 && k < r2 + ROLL);
         exp_v = (r1 >= 0 && k == r1 + ROLL) || (r2 >= 0 && k == r2 + ROLL);
         check($sformatf("rolling@%0d", k), rolling, exp_r);
         check($sformatf("result_valid@%0d", k), result_valid, exp_v);
      end
      btn = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      btn   = 1'b0;
`ifdef DICE_HOLD_EN
      hold  = 2'b00;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 50; k++) begin
         check("reset_dice_out", dice_out, 0);
         check("reset_dice_sum", dice_sum, 0);
         check("reset_rolling", rolling, 0);
         check("reset_result_valid", result_valid, 0);
         @(posedge clk);
         #1;
      end

      run_seq(12, 0, 0, 7, -1, 24);   // clean press
      run_seq(4, 4, 8, 7, -1, 30);    // second press pulse lands on final ROLL cycle: dropped
      run_seq(12, 0, 0, 7, -1, 24);   // follow-up press starts a new roll
      run_seq(4, 5, 8, 7, 16, 34);    // second press pulse coincides with result_valid: accepted
      run_seq(3, 3, 3, -1, -1, 20);   // bounces shorter than debounce window

      // Reset on the 4th cycle of rolling.
      btn = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk);
         #1;
      end
      check("rolling_before_abort", rolling, 1);
      reset = 1'b1;
      btn   = 1'b0;
      @(posedge clk);
      #1;
      check("abort_rolling", rolling, 0);
      check("abort_dice_out", dice_out, 0);
      check("abort_dice_sum", dice_sum, 0);
      check("abort_result_valid", result_valid, 0);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         check("post_abort_result_valid", result_valid, 0);
      end
      run_seq(12, 0, 0, 7, -1, 24);   // LFSR restarted from seed

`ifdef DICE_HOLD_EN
      hold      = 2'b01;
      hold_mask = 2'b01;
      run_seq(12, 0, 0, 7, -1, 24);
      hold      = 2'b00;
      hold_mask = 2'b00;
`endif

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
